// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC calibration controller.
//   state_t   : controller state encoding
//   ERR_*     : err_code values reported on a failed sequence
//   MODE_*    : OpMode drive values (both ADCs together)
//   max4()    : helper used to size the shared cycle counter
package adc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWRUP,
    ST_RESET,
    ST_CAL_H,
    ST_WAIT_H_RISE,
    ST_WAIT_H_FALL,
    ST_CAL_L,
    ST_WAIT_L_RISE,
    ST_WAIT_L_FALL,
    ST_DONE,
    ST_ERROR
  } state_t;

  localparam logic [1:0] ERR_NONE   = 2'b00;
  localparam logic [1:0] ERR_H_RISE = 2'b01;
  localparam logic [1:0] ERR_H_FALL = 2'b10;
  localparam logic [1:0] ERR_L      = 2'b11;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_ON  = 2'b11;

  localparam logic [1:0] CAL_NONE = 2'b00;
  localparam logic [1:0] CAL_H    = 2'b10;
  localparam logic [1:0] CAL_L    = 2'b01;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/adc_sync2.sv
// Two-flop synchronizer, one independent chain per bit.
//   clk   : destination clock
//   rst_b : asynchronous active-low reset, clears both stages
//   d     : asynchronous input bits
//   q     : synchronized output bits (two-cycle latency)
module adc_sync2 #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_b,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_cal_ctrl.sv
// Power-up / reset / calibration sequencer for a high-gain + low-gain ADC pair.
//   ClkIn    : system clock, rising edge
//   rst_b    : asynchronous active-low reset
//   start    : one-cycle request to run the full sequence (IDLE/DONE/ERROR only)
//   abort    : cancel a running sequence, outputs return to reset values
//   CalBusy  : ADC calibration busy, [1]=high gain, [0]=low gain (asynchronous)
//   OpMode   : per-ADC operating mode (0 power-down, 1 normal)
//   AdcRst_b : per-ADC reset, active-low
//   CalIn    : per-ADC calibration request, never both bits at once
//   busy     : sequence in progress
//   done     : sticky, last sequence completed
//   err      : sticky, last sequence failed
//   err_code : failure cause (01 H rise, 10 H fall, 11 L rise/fall timeout)
//
// state        | meaning
// -------------+---------------------------------------------------------
// IDLE         | powered down, waiting for start
// PWRUP        | ADCs powered, held in reset for the settle time
// RESET        | reset pulse continues for the reset width
// CAL_H        | CalIn pulse to the high-gain ADC
// WAIT_H_RISE  | wait for high-gain CalBusy to assert (timed)
// WAIT_H_FALL  | wait for high-gain CalBusy to release (timed)
// CAL_L        | CalIn pulse to the low-gain ADC
// WAIT_L_RISE  | wait for low-gain CalBusy to assert (timed)
// WAIT_L_FALL  | wait for low-gain CalBusy to release (timed)
// DONE         | sequence finished, ADCs running
// ERROR        | sequence failed, ADC mode/reset left as they were
module adc_cal_ctrl
  import adc_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC    = 1024,
  parameter int unsigned RST_CYC       = 16,
  parameter int unsigned CAL_PULSE_CYC = 8,
  parameter int unsigned BUSY_TIMEOUT  = 65535
) (
  input  logic       ClkIn,
  input  logic       rst_b,
  input  logic       start,
  input  logic       abort,
  input  logic [1:0] CalBusy,
  output logic [1:0] OpMode,
  output logic [1:0] AdcRst_b,
  output logic [1:0] CalIn,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [1:0] err_code
);

  localparam int unsigned MAX_CYC = max4(SETTLE_CYC, RST_CYC, CAL_PULSE_CYC, BUSY_TIMEOUT);
  localparam int unsigned CNT_W   = $clog2(MAX_CYC + 1);

  // Each state exits when the counter reaches its last cycle, so the counter
  // never exceeds (parameter - 1) and cannot wrap.
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYC - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(CAL_PULSE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       busy_sync;

  adc_sync2 #(.W(2)) u_sync (
    .clk   (ClkIn),
    .rst_b (rst_b),
    .d     (CalBusy),
    .q     (busy_sync)
  );

  always_ff @(posedge ClkIn or negedge rst_b) begin
    if (!rst_b) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      OpMode   <= MODE_OFF;
      AdcRst_b <= 2'b00;
      CalIn    <= CAL_NONE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else if (abort && busy) begin
      // Abort wins over any exit the current state would take this cycle.
      state    <= ST_IDLE;
      cnt      <= '0;
      OpMode   <= MODE_OFF;
      AdcRst_b <= 2'b00;
      CalIn    <= CAL_NONE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state    <= ST_PWRUP;
            cnt      <= '0;
            OpMode   <= MODE_ON;
            AdcRst_b <= 2'b00;
            CalIn    <= CAL_NONE;
            busy     <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= ERR_NONE;
          end
        end

        ST_PWRUP: begin
          if (cnt == SETTLE_LAST) begin
            state <= ST_RESET;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_RESET: begin
          if (cnt == RST_LAST) begin
            state    <= ST_CAL_H;
            cnt      <= '0;
            AdcRst_b <= 2'b11;
            CalIn    <= CAL_H;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_CAL_H: begin
          if (cnt == PULSE_LAST) begin
            state <= ST_WAIT_H_RISE;
            cnt   <= '0;
            CalIn <= CAL_NONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        // Busy edge is tested before the timeout so a same-cycle edge succeeds.
        ST_WAIT_H_RISE: begin
          if (busy_sync[1]) begin
            state <= ST_WAIT_H_FALL;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state    <= ST_ERROR;
            cnt      <= '0;
            CalIn    <= CAL_NONE;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_H_RISE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_WAIT_H_FALL: begin
          if (!busy_sync[1]) begin
            state <= ST_CAL_L;
            cnt   <= '0;
            CalIn <= CAL_L;
          end else if (cnt == TIMEOUT_LAST) begin
            state    <= ST_ERROR;
            cnt      <= '0;
            CalIn    <= CAL_NONE;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_H_FALL;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_CAL_L: begin
          if (cnt == PULSE_LAST) begin
            state <= ST_WAIT_L_RISE;
            cnt   <= '0;
            CalIn <= CAL_NONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_WAIT_L_RISE: begin
          if (busy_sync[0]) begin
            state <= ST_WAIT_L_FALL;
            cnt   <= '0;
          end else if (cnt == TIMEOUT_LAST) begin
            state    <= ST_ERROR;
            cnt      <= '0;
            CalIn    <= CAL_NONE;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_L;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ST_WAIT_L_FALL: begin
          if (!busy_sync[0]) begin
            state    <= ST_DONE;
            cnt      <= '0;
            OpMode   <= MODE_ON;
            AdcRst_b <= 2'b11;
            CalIn    <= CAL_NONE;
            busy     <= 1'b0;
            done     <= 1'b1;
          end else if (cnt == TIMEOUT_LAST) begin
            state    <= ST_ERROR;
            cnt      <= '0;
            CalIn    <= CAL_NONE;
            busy     <= 1'b0;
            err      <= 1'b1;
            err_code <= ERR_L;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        default: begin
          state    <= ST_IDLE;
          cnt      <= '0;
          OpMode   <= MODE_OFF;
          AdcRst_b <= 2'b00;
          CalIn    <= CAL_NONE;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_cal_ctrl.sv
// Directed bench for adc_cal_ctrl with small timing parameters.
// A per-cycle BFM answers each CalIn pulse with a CalBusy pulse whose delay
// and width come from the scenario table (-1 = never rises / never falls).
module tb_adc_cal_ctrl;

  logic       ClkIn = 1'b0;
  logic       rst_b = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [1:0] CalBusy = 2'b00;
  logic [1:0] OpMode, AdcRst_b, CalIn, err_code;
  logic       busy, done, err;

  adc_cal_ctrl #(
    .SETTLE_CYC    (4),
    .RST_CYC       (2),
    .CAL_PULSE_CYC (3),
    .BUSY_TIMEOUT  (10)
  ) dut (
    .ClkIn    (ClkIn),
    .rst_b    (rst_b),
    .start    (start),
    .abort    (abort),
    .CalBusy  (CalBusy),
    .OpMode   (OpMode),
    .AdcRst_b (AdcRst_b),
    .CalIn    (CalIn),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .err_code (err_code)
  );

  always #5 ClkIn = ~ClkIn;

  int n_chk = 0;
  int n_fail = 0;

  // BFM / tracking state
  int k = 0;
  int t_h, t_l, t_rst, t_err, cnt10, cnt01;
  int rise_h, hold_h, rise_l, hold_l;
  logic [1:0] prev_calin = 2'b00;
  bit calin_both = 1'b0;

  typedef struct {
    int rh, hh, rl, hl;
    int done_e, err_e, code_e, w01_e;
    int lat_ref;   // 0 none, 1 latency from H drop, 2 from L drop
    int lat_e;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs[NV];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic bfm_active(input int t, input int rise, input int hold, input int kk);
    return (rise >= 0) && (t >= 0) && (kk >= t + rise) && ((hold < 0) || (kk < t + rise + hold));
  endfunction

  task automatic arm(input int rh, input int hh, input int rl, input int hl);
    rise_h = rh; hold_h = hh; rise_l = rl; hold_l = hl;
    t_h = -1; t_l = -1; t_rst = -1; t_err = -1;
    cnt10 = 0; cnt01 = 0; calin_both = 1'b0;
    prev_calin = CalIn;
  endtask

  task automatic step();
    @(posedge ClkIn);
    #1;
    k++;
    if (prev_calin == 2'b10 && CalIn == 2'b00) t_h = k;
    if (prev_calin == 2'b01 && CalIn == 2'b00) t_l = k;
    prev_calin = CalIn;
    if (CalIn == 2'b11) calin_both = 1'b1;
    if (CalIn == 2'b10) cnt10++;
    if (CalIn == 2'b01) cnt01++;
    if (AdcRst_b == 2'b11 && t_rst < 0) t_rst = k;
    if (err && t_err < 0) t_err = k;
    CalBusy = {bfm_active(t_h, rise_h, hold_h, k), bfm_active(t_l, rise_l, hold_l, k)};
  endtask

  task automatic run_to_end(input string tag);
    int guard;
    guard = 0;
    while (busy && guard < 300) begin
      step();
      guard++;
    end
    chk({tag, "_end_bound"}, int'(guard < 300), 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_opmode"}, int'(OpMode), 0);
    chk({tag, "_adcrst"}, int'(AdcRst_b), 0);
    chk({tag, "_calin"}, int'(CalIn), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_code"}, int'(err_code), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ts;
    int guard;
    string tag;

    //           rh  hh  rl  hl done err code w01 ref lat
    vecs[0]  = '{ 5,  6,  5,  6, 1, 0, 0, 3, 0,  0};  // nominal
    vecs[1]  = '{-1,  0,  5,  6, 0, 1, 1, 0, 1, 10};  // H never busy
    vecs[2]  = '{ 8,  6,  5,  6, 0, 1, 1, 0, 1, 10};  // H rise one cycle late
    vecs[3]  = '{ 7,  6,  5,  6, 1, 0, 0, 3, 0,  0};  // H rise on timeout cycle
    vecs[4]  = '{ 5, -1,  5,  6, 0, 1, 2, 0, 1, 18};  // H stuck busy
    vecs[5]  = '{ 5, 11,  5,  6, 0, 1, 2, 0, 1, 18};  // H fall one cycle late
    vecs[6]  = '{ 5, 10,  5,  6, 1, 0, 0, 3, 0,  0};  // H fall on timeout cycle
    vecs[7]  = '{ 5,  6, -1,  0, 0, 1, 3, 3, 2, 10};  // L never busy
    vecs[8]  = '{ 5,  6,  5, -1, 0, 1, 3, 3, 2, 18};  // L stuck busy
    vecs[9]  = '{ 5,  6,  5, 11, 0, 1, 3, 3, 2, 18};  // L fall one cycle late
    vecs[10] = '{ 5,  6,  7, 10, 1, 0, 0, 3, 0,  0};  // L both boundaries met

    arm(-1, 0, -1, 0);
    #2 rst_b = 1'b0;
    #1 check_reset_outputs("por");
    repeat (2) @(posedge ClkIn);
    @(negedge ClkIn);
    rst_b = 1'b1;

    for (int i = 0; i < NV; i++) begin
      tag = $sformatf("v%0d", i);
      arm(vecs[i].rh, vecs[i].hh, vecs[i].rl, vecs[i].hl);
      start = 1'b1;
      step();
      start = 1'b0;
      ts = k;
      chk({tag, "_go_busy"}, int'(busy), 1);
      chk({tag, "_go_done"}, int'(done), 0);
      chk({tag, "_go_err"}, int'(err), 0);
      chk({tag, "_go_code"}, int'(err_code), 0);
      chk({tag, "_go_opmode"}, int'(OpMode), 3);
      chk({tag, "_go_adcrst"}, int'(AdcRst_b), 0);
      run_to_end(tag);
      chk({tag, "_rst_delay"}, t_rst - ts, 6);
      chk({tag, "_calh_width"}, cnt10, 3);
      chk({tag, "_call_width"}, cnt01, vecs[i].w01_e);
      chk({tag, "_done"}, int'(done), vecs[i].done_e);
      chk({tag, "_err"}, int'(err), vecs[i].err_e);
      chk({tag, "_code"}, int'(err_code), vecs[i].code_e);
      chk({tag, "_calin_end"}, int'(CalIn), 0);
      chk({tag, "_opmode_end"}, int'(OpMode), 3);
      chk({tag, "_adcrst_end"}, int'(AdcRst_b), 3);
      chk({tag, "_calin_both"}, int'(calin_both), 0);
      if (vecs[i].lat_ref == 1) chk({tag, "_err_lat"}, t_err - t_h, vecs[i].lat_e);
      if (vecs[i].lat_ref == 2) chk({tag, "_err_lat"}, t_err - t_l, vecs[i].lat_e);
      arm(-1, 0, -1, 0);
      repeat (3) step();
    end

    // abort outside a running sequence does nothing
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abort_idle_done", int'(done), 1);
    chk("abort_idle_busy", int'(busy), 0);
    chk("abort_idle_opmode", int'(OpMode), 3);

    // abort on the last PWRUP cycle beats the move to RESET
    arm(-1, 0, -1, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_reset_outputs("abort_pwrup");
    repeat (2) step();
    chk("abort_pwrup_stays", int'(busy), 0);

    // abort during WAIT_H_FALL, then a full rerun
    arm(5, -1, 5, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (t_h < 0 && guard < 50) begin
      step();
      guard++;
    end
    chk("abort_hf_reach", int'(guard < 50), 1);
    while (k < t_h + 10 && guard < 100) begin
      step();
      guard++;
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    check_reset_outputs("abort_hf");
    arm(-1, 0, -1, 0);
    repeat (3) step();
    chk("abort_hf_no_late_err", int'(err), 0);
    arm(5, 6, 5, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    ts = k;
    chk("rerun_opmode", int'(OpMode), 3);
    chk("rerun_adcrst", int'(AdcRst_b), 0);
    run_to_end("rerun");
    chk("rerun_rst_delay", t_rst - ts, 6);
    chk("rerun_calh", cnt10, 3);
    chk("rerun_call", cnt01, 3);
    chk("rerun_done", int'(done), 1);

    // asynchronous reset during CAL_L, immediate restart, ignored re-start
    arm(5, 6, 5, 6);
    start = 1'b1;
    step();
    start = 1'b0;
    guard = 0;
    while (CalIn != 2'b01 && guard < 100) begin
      step();
      guard++;
    end
    chk("rst_cal_l_reach", int'(guard < 100), 1);
    #2 rst_b = 1'b0;
    #1 check_reset_outputs("rst_async");
    #2;
    arm(5, 6, 5, 6);
    CalBusy = 2'b00;
    rst_b = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    ts = k;
    chk("first_edge_start_busy", int'(busy), 1);
    chk("first_edge_start_opmode", int'(OpMode), 3);
    repeat (2) step();
    start = 1'b1;
    step();
    start = 1'b0;
    run_to_end("restart");
    chk("start_ignored_rst_delay", t_rst - ts, 6);
    chk("restart_done", int'(done), 1);
    chk("restart_err", int'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
